ac_ostream: RTL
===============

Name: ac_ostream

Overview:
- AXI-Stream master stage directly downstream of the access-control output buffer.
- Pops wide words (N_PARALLEL pixel packages) from the buffer's read port and presents them on the IP-to-PS AXI-Stream bus.
- Generates frame framing: tuser on the first beat of a frame, tlast on the last beat of each row, tkeep for a partial row-end beat.
- Absorbs tready backpressure with a 2-entry skid buffer and sustains 1 beat/cycle.

Parameters:
- UPSP_WRTDATA_WIDTH, 24, width of one pixel package; multiple of 24.
- N_PARALLEL, 2, packages per AXIS beat.
- DST_IMG_WIDTH, 4096, destination pixels per row.
- DST_IMG_HEIGHT, 2160, destination rows per frame.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- buf_empty  input  1  output buffer has no complete wide word
- buf_rdata  input  UPSP_WRTDATA_WIDTH*N_PARALLEL  wide word; valid the cycle after buf_rd; first package in the MS lane
- buf_rd  output  1  pop request to the output buffer
- m_axis_tdata  output  UPSP_WRTDATA_WIDTH*N_PARALLEL  stream data
- m_axis_tkeep  output  UPSP_WRTDATA_WIDTH*N_PARALLEL/8  byte enables
- m_axis_tvalid  output  1  beat valid
- m_axis_tready  input  1  sink ready
- m_axis_tlast  output  1  last beat of a row
- m_axis_tuser  output  1  first beat of a frame
- frame_done  output  1  one-cycle pulse after the final beat of a frame is accepted

Behaviour:
- Derived constants:
  - N_UPSP_WRT = UPSP_WRTDATA_WIDTH/24
  - N_ROW_PACKAGE = DST_IMG_WIDTH/N_UPSP_WRT
  - BEATS_PER_ROW = ceil(N_ROW_PACKAGE/N_PARALLEL)
  - ROWEND_POS = (N_ROW_PACKAGE-1) % N_PARALLEL
- Reset: buf_rd=0, m_axis_tvalid=0, tlast=0, tuser=0, frame_done=0, tdata=0, tkeep=0. Skid empty, in-flight flag clear, beat_cnt=0, row_cnt=0.
- Read latency: buf_rdata is sampled into the skid one cycle after buf_rd. At most one read is in flight.
- Pop definition: pop = m_axis_tvalid & m_axis_tready.
- Read issue: buf_rd = ~buf_empty & ((occ+inflight < 2) | (occ+inflight == 2 & pop)), where occ is skid occupancy (0..2).
  - buf_rd has a combinational path from m_axis_tready; this is accepted.
- Skid buffer: 2-entry FIFO of {data, keep, last, user}.
  - Head drives the AXIS outputs. m_axis_tvalid = (occ != 0).
  - Simultaneous write and pop: occupancy unchanged, order preserved.
  - Overflow is impossible by construction. Debug-assert occ+inflight <= 2.
- Framing counters: beat_cnt 0..BEATS_PER_ROW-1 and row_cnt 0..DST_IMG_HEIGHT-1 are attached at skid write time, not pop time.
  - On each skid write, beat_cnt increments.
  - At BEATS_PER_ROW-1, beat_cnt wraps to 0 and row_cnt increments.
  - At the last row, row_cnt wraps to 0.
- Sideband fields per beat:
  - user = (beat_cnt==0 & row_cnt==0)
  - last = (beat_cnt==BEATS_PER_ROW-1)
  - keep = all-ones, except on a row-end beat when N_ROW_PACKAGE % N_PARALLEL != 0. There the upper (ROWEND_POS+1)*UPSP_WRTDATA_WIDTH/8 bytes are 1 and the lower bytes are 0 (lower lanes carry padding).
- frame_done: registered; pulses the cycle after a pop whose beat has last=1 and was written with row_cnt==DST_IMG_HEIGHT-1. The next frame starts with no idle cycle required.
- AXIS rule: once tvalid=1, tdata/tkeep/tlast/tuser stay stable until pop.
- Empty buffer mid-row: tvalid drops once the skid drains. Counters hold; the stream resumes at the correct beat.
- Sink stall: the skid fills to 2, buf_rd deasserts, the buffer back-pressures upstream.
- Reset mid-frame: all state clears asynchronously. The next frame starts with tuser=1. Resynchronising the upstream buffer is the system's responsibility (shared reset).

Decomposition:
- Shared package/header: N_UPSP_WRT, BEATS_PER_ROW, ROWEND_POS, last-beat keep-mask function. This gives ac_outbuf and ac_ostream one definition of row-end packing.
- One sub-module is natural: ac_skid2, a generic 2-entry skid FIFO with occupancy output. Counters and read-issue logic stay in the top.

Test Plan:
- W=8, H=2, NP=2, 24b; 8 words preloaded, tready=1 -> buf_rd high 8 consecutive cycles; 8 beats back-to-back; tuser on beat 0 only; tlast on beats 3 and 7; tkeep=6'h3F; frame_done one cycle after beat 7.
- W=6, H=1, NP=4 -> 2 beats; beat 0 tkeep=12'hFFF tlast=0; beat 1 tkeep=12'hFC0 tlast=1.
- Random tready (50%) over 3 frames of W=8, H=2 -> data order matches push order; never >1 in-flight read; occ+inflight<=2; tdata stable while tvalid & ~tready.
- tready=0 for 10 cycles with a full buffer -> exactly 2 reads issued, tvalid held with beat 0 data; release -> 1 beat/cycle resumes, no loss or duplication.
- buf_empty toggled every other cycle mid-row -> tvalid gaps; tlast still on the 4th beat of each row.
- rst_n asserted after beat 5 of frame 1, then new data -> outputs zero during reset; first beat after reset has tuser=1, beat_cnt=0.

Source files
------------

// File: rtl/ac_ostream_pkg.sv
// Shared frame-geometry helpers for the access-control output path, so the
// output buffer and the stream stage agree on row-end packing.
package ac_ostream_pkg;
  localparam int PIX_BITS = 24;
  localparam int KEEP_MAX = 1024;

  function automatic int n_upsp_wrt(input int upsp_w);
    return upsp_w / PIX_BITS;
  endfunction

  function automatic int n_row_package(input int img_w, input int upsp_w);
    return img_w / n_upsp_wrt(upsp_w);
  endfunction

  function automatic int beats_per_row(input int n_row_pkg, input int np);
    return (n_row_pkg + np - 1) / np;
  endfunction

  function automatic int rowend_pos(input int n_row_pkg, input int np);
    return (n_row_pkg - 1) % np;
  endfunction

  // Final packages of a row sit in the upper lanes; lower lanes are padding.
  function automatic logic [KEEP_MAX-1:0] rowend_keep(input int n_row_pkg, input int np,
                                                      input int upsp_w);
    int total;
    int upper;
    logic [KEEP_MAX-1:0] mask;
    total = upsp_w * np / 8;
    upper = (n_row_pkg % np == 0) ? total : (rowend_pos(n_row_pkg, np) + 1) * upsp_w / 8;
    mask  = '0;
    for (int b = 0; b < KEEP_MAX; b++) begin
      if (b < total && b >= total - upper) mask[b] = 1'b1;
    end
    return mask;
  endfunction
endpackage

// File: rtl/ac_ostream_skid2.sv
// Generic 2-entry skid FIFO; head is registered and drives the consumer directly.
module ac_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({wr_en, rd_en})
      2'b10: begin
        if (occ_q == 2'd0) head_d = wr_data;
        else               tail_d = wr_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; with two entries the tail advances to the head.
        if (occ_q == 2'd1) begin
          head_d = wr_data;
        end else begin
          head_d = tail_q;
          tail_d = wr_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head = head_q;
  assign occ  = occ_q;
endmodule

// File: rtl/ac_ostream.sv
// AXI-Stream master after the access-control output buffer: pops wide words,
// attaches frame sideband at write time, and absorbs tready stalls in a skid.
module ac_ostream
  import ac_ostream_pkg::*;
#(
  parameter int UPSP_WRTDATA_WIDTH = 24,
  parameter int N_PARALLEL         = 2,
  parameter int DST_IMG_WIDTH      = 4096,
  parameter int DST_IMG_HEIGHT     = 2160
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      buf_empty,
  input  logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0]  buf_rdata,
  output logic                                      buf_rd,
  output logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0]  m_axis_tdata,
  output logic [UPSP_WRTDATA_WIDTH*N_PARALLEL/8-1:0] m_axis_tkeep,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  output logic                                      m_axis_tuser,
  output logic                                      frame_done
);
  localparam int DW            = UPSP_WRTDATA_WIDTH * N_PARALLEL;
  localparam int KW            = DW / 8;
  localparam int N_ROW_PACKAGE = n_row_package(DST_IMG_WIDTH, UPSP_WRTDATA_WIDTH);
  localparam int BEATS_PER_ROW = beats_per_row(N_ROW_PACKAGE, N_PARALLEL);
  localparam int BEAT_W        = $clog2(BEATS_PER_ROW + 1);
  localparam int ROW_W         = $clog2(DST_IMG_HEIGHT + 1);
  localparam int SW            = DW + KW + 3;
  localparam logic [KEEP_MAX-1:0] ROWEND_KEEP_ALL =
    rowend_keep(N_ROW_PACKAGE, N_PARALLEL, UPSP_WRTDATA_WIDTH);
  localparam logic [KW-1:0] KEEP_ROWEND = ROWEND_KEEP_ALL[KW-1:0];

  logic              inflight_q, inflight_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic              frame_done_q, frame_done_d;

  logic [1:0]    occ;
  logic [2:0]    pending;
  logic [SW-1:0] wr_entry;
  logic [SW-1:0] head;
  logic          pop;
  logic          row_end;
  logic          frame_end;
  logic          first_beat;
  logic          head_flast;
  logic [KW-1:0] wr_keep;

  assign pop     = m_axis_tvalid & m_axis_tready;
  assign pending = {1'b0, occ} + {2'b00, inflight_q};
  // A pop this cycle frees a slot, so a full pipe can still issue a read.
  assign buf_rd  = ~buf_empty & ((pending < 3'd2) | ((pending == 3'd2) & pop));

  assign row_end    = (beat_cnt_q == BEAT_W'(BEATS_PER_ROW - 1));
  assign frame_end  = row_end & (row_cnt_q == ROW_W'(DST_IMG_HEIGHT - 1));
  assign first_beat = (beat_cnt_q == '0) & (row_cnt_q == '0);
  assign wr_keep    = row_end ? KEEP_ROWEND : {KW{1'b1}};
  assign wr_entry   = {frame_end, first_beat, row_end, wr_keep, buf_rdata};

  always_comb begin
    inflight_d   = buf_rd;
    beat_cnt_d   = beat_cnt_q;
    row_cnt_d    = row_cnt_q;
    frame_done_d = pop & head_flast;
    if (inflight_q) begin
      if (row_end) begin
        beat_cnt_d = '0;
        row_cnt_d  = frame_end ? '0 : row_cnt_q + 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= 1'b0;
      beat_cnt_q   <= '0;
      row_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      beat_cnt_q   <= beat_cnt_d;
      row_cnt_q    <= row_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  ac_skid2 #(.W(SW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight_q),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .head    (head),
    .occ     (occ)
  );

  assign m_axis_tdata  = head[DW-1:0];
  assign m_axis_tkeep  = head[DW+KW-1:DW];
  assign m_axis_tlast  = head[DW+KW];
  assign m_axis_tuser  = head[DW+KW+1];
  assign head_flast    = head[DW+KW+2];
  assign m_axis_tvalid = (occ != 2'd0);
  assign frame_done    = frame_done_q;

  a_pending_bound: assert property (@(posedge clk) disable iff (!rst_n) pending <= 3'd2);
endmodule
